// File: rtl/apb4_master_pkg.sv
// Shared types and constants for the APB4 requester bridge.
// Optional ACCESS timeout is enabled by defining APB4_MASTER_TIMEOUT_EN.
`ifndef APB4_MASTER_STRB_WIDTH
`define APB4_MASTER_STRB_WIDTH(dw) ((dw) / 8)
`endif

package apb4_master_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    localparam logic [2:0] PPROT_DEFAULT = 3'b000;
endpackage

// File: rtl/apb4_master_timeout.sv
// ACCESS-phase wait counter; expired_o flags the last permitted stalled cycle.
module apb4_master_timeout #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)     cnt <= '0;
        else if (clear_i) cnt <= '0;
        else if (en_i)    cnt <= cnt + 1'b1;
    end

    // The increment on this cycle would bring the count to the limit.
    assign expired_o = en_i && (cnt == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/register.sv
// Basic flop cells: dffr (async active-low reset) and dffer (with load enable).
module dffr #(
    parameter int             W   = 1,
    parameter logic [W-1:0]   RST = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= RST;
        else        q <= d;
    end
endmodule

module dffer #(
    parameter int             W   = 1,
    parameter logic [W-1:0]   RST = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= RST;
        else if (en) q <= d;
    end
endmodule

// File: rtl/apb4_master.sv
// APB4 requester bridge: one outstanding valid/ready request mapped onto SETUP/ACCESS.
// Define APB4_MASTER_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT_CYCLES.
module apb4_master
    import apb4_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                      clk_i,
    input  logic                                      rst_n_i,
    input  logic                                      req_valid_i,
    output logic                                      req_ready_o,
    input  logic                                      req_write_i,
    input  logic [ADDR_WIDTH-1:0]                     req_addr_i,
    input  logic [DATA_WIDTH-1:0]                     req_wdata_i,
    input  logic [`APB4_MASTER_STRB_WIDTH(DATA_WIDTH)-1:0] req_strb_i,
    input  logic [2:0]                                req_prot_i,
    output logic                                      rsp_valid_o,
    input  logic                                      rsp_ready_i,
    output logic [DATA_WIDTH-1:0]                     rsp_rdata_o,
    output logic                                      rsp_err_o,
    output logic [ADDR_WIDTH-1:0]                     paddr_o,
    output logic [2:0]                                pprot_o,
    output logic                                      psel_o,
    output logic                                      penable_o,
    output logic                                      pwrite_o,
    output logic [DATA_WIDTH-1:0]                     pwdata_o,
    output logic [`APB4_MASTER_STRB_WIDTH(DATA_WIDTH)-1:0] pstrb_o,
    input  logic                                      pready_i,
    input  logic [DATA_WIDTH-1:0]                     prdata_i,
    input  logic                                      pslverr_i
);
    localparam int SW = `APB4_MASTER_STRB_WIDTH(DATA_WIDTH);

    logic [1:0]      state_q;
    apb_state_e      state, state_d;
    logic            accept, in_access, acc_done, rsp_take, timeout;
    logic            psel_d, penable_d, rsp_valid_d, rsp_err_d;
    logic [SW-1:0]   strb_d;
    logic [DATA_WIDTH-1:0] rdata_d;

    assign state       = apb_state_e'(state_q);
    assign req_ready_o = (state == IDLE);
    assign accept      = req_valid_i && req_ready_o;
    assign in_access   = (state == ACCESS);
    assign acc_done    = in_access && (pready_i || timeout);
    assign rsp_take    = (state == RESP) && rsp_ready_i;

`ifdef APB4_MASTER_TIMEOUT_EN
    apb4_master_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clear_i   (state == SETUP),
        .en_i      (in_access && !pready_i),
        .expired_o (timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept)      state_d = SETUP;
            SETUP:                    state_d = ACCESS;
            ACCESS:  if (acc_done)    state_d = RESP;
            RESP:    if (rsp_ready_i) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    dffr #(.W(2)) u_state (.clk(clk_i), .rst_n(rst_n_i), .d(state_d), .q(state_q));

    assign psel_d      = accept | (psel_o & ~acc_done);
    assign penable_d   = (state == SETUP) | (penable_o & ~acc_done);
    assign rsp_valid_d = acc_done | (rsp_valid_o & ~rsp_take);

    dffr u_psel   (.clk(clk_i), .rst_n(rst_n_i), .d(psel_d),      .q(psel_o));
    dffr u_penable(.clk(clk_i), .rst_n(rst_n_i), .d(penable_d),   .q(penable_o));
    dffr u_rspv   (.clk(clk_i), .rst_n(rst_n_i), .d(rsp_valid_d), .q(rsp_valid_o));

    // Request fields are frozen into the APB outputs at acceptance and held for the whole transfer.
    assign strb_d = req_write_i ? req_strb_i : '0;

    dffer #(.W(1))          u_pwrite(.clk(clk_i), .rst_n(rst_n_i), .en(accept), .d(req_write_i), .q(pwrite_o));
    dffer #(.W(ADDR_WIDTH)) u_paddr (.clk(clk_i), .rst_n(rst_n_i), .en(accept), .d(req_addr_i),  .q(paddr_o));
    dffer #(.W(DATA_WIDTH)) u_pwdata(.clk(clk_i), .rst_n(rst_n_i), .en(accept), .d(req_wdata_i), .q(pwdata_o));
    dffer #(.W(SW))         u_pstrb (.clk(clk_i), .rst_n(rst_n_i), .en(accept), .d(strb_d),      .q(pstrb_o));
    dffer #(.W(3), .RST(PPROT_DEFAULT)) u_pprot (
        .clk(clk_i), .rst_n(rst_n_i), .en(accept), .d(req_prot_i), .q(pprot_o));

    // A timeout completes without pready: error, no data.
    assign rdata_d   = (pready_i && !pwrite_o) ? prdata_i : '0;
    assign rsp_err_d = pready_i ? pslverr_i : 1'b1;

    dffer #(.W(DATA_WIDTH)) u_rdata(.clk(clk_i), .rst_n(rst_n_i), .en(acc_done), .d(rdata_d),   .q(rsp_rdata_o));
    dffer #(.W(1))          u_err  (.clk(clk_i), .rst_n(rst_n_i), .en(acc_done), .d(rsp_err_d), .q(rsp_err_o));
endmodule

// File: tb/tb_apb4_master.sv
// Directed + randomized bench for apb4_master; expected timing and data come from transfer-level rules.
module tb_apb4_master;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] paddr, pwdata, prdata;
    logic [2:0]  pprot;
    logic        psel, penable, pwrite, pready, pslverr;
    logic [3:0]  pstrb;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    apb4_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_strb_i(req_strb), .req_prot_i(req_prot),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .paddr_o(paddr), .pprot_o(pprot), .psel_o(psel), .penable_o(penable), .pwrite_o(pwrite),
        .pwdata_o(pwdata), .pstrb_o(pstrb), .pready_i(pready), .prdata_i(prdata), .pslverr_i(pslverr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transfer. Starts 1ns after a rising edge with the bridge idle; ends the same way.
    // The slave answers after 'waits' stalled ACCESS cycles; the requester stalls the response 'hold' cycles.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                        input logic [2:0] pr, input int waits, input logic [31:0] rd, input logic er,
                        input int hold, output int t_acc);
        logic [3:0]  est;
        logic [31:0] erd;
        est = wr ? st : 4'h0;
        erd = wr ? 32'h0 : rd;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_strb = st; req_prot = pr;
        pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
        @(negedge clk);
        chk("idle_req_ready", {31'd0, req_ready}, 32'd1);
        t_acc = cyc;
        @(posedge clk); #1;
        req_valid = 1'($urandom); req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
        @(negedge clk);
        chk("setup_psel", {31'd0, psel}, 32'd1);
        chk("setup_penable", {31'd0, penable}, 32'd0);
        chk("setup_paddr", paddr, a);
        chk("setup_pwrite", {31'd0, pwrite}, {31'd0, wr});
        chk("setup_pwdata", pwdata, wd);
        chk("setup_pstrb", {28'd0, pstrb}, {28'd0, est});
        chk("setup_pprot", {29'd0, pprot}, {29'd0, pr});
        for (int k = 0; k <= waits; k++) begin
            @(posedge clk); #1;
            pready  = (k == waits);
            prdata  = (k == waits) ? rd : $urandom;
            pslverr = (k == waits) ? er : 1'($urandom);
            req_valid = 1'($urandom); req_addr = $urandom;
            @(negedge clk);
            chk("access_psel", {31'd0, psel}, 32'd1);
            chk("access_penable", {31'd0, penable}, 32'd1);
            chk("access_paddr", paddr, a);
            chk("access_pwdata", pwdata, wd);
            chk("access_pstrb", {28'd0, pstrb}, {28'd0, est});
            chk("access_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end
        @(posedge clk); #1;
        pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
        req_valid = 1'($urandom); rsp_ready = (hold == 0);
        @(negedge clk);
        chk("rsp_latency", cyc - t_acc, 3 + waits);
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_rdata", rsp_rdata, erd);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, er});
        chk("rsp_psel", {31'd0, psel}, 32'd0);
        chk("rsp_penable", {31'd0, penable}, 32'd0);
        chk("rsp_req_ready", {31'd0, req_ready}, 32'd0);
        for (int h = 1; h <= hold; h++) begin
            @(posedge clk); #1;
            rsp_ready = (h == hold); req_valid = 1'($urandom);
            @(negedge clk);
            chk("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_rsp_err", {31'd0, rsp_err}, {31'd0, er});
            chk("hold_rsp_rdata", rsp_rdata, erd);
            chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0; req_valid = 1'b0; pready = 1'b0;
    endtask

    initial begin
        int t0, t1, w, h;
        int nacc;
        bit got;
        logic wr, er;
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_strb = '0; req_prot = '0; rsp_ready = 1'b0; pready = 1'b0; prdata = '0; pslverr = 1'b0;
        #2;
        chk("rst_psel", {31'd0, psel}, 32'd0);
        chk("rst_penable", {31'd0, penable}, 32'd0);
        chk("rst_pwrite", {31'd0, pwrite}, 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_pstrb", {28'd0, pstrb}, 32'd0);
        chk("rst_pprot", {29'd0, pprot}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Zero-wait write, wait-stated read, erroring write with a stalled response.
        xfer(1'b1, 32'h0000_0004, 32'h0000_0003, 4'hF, 3'b000, 0, 32'hDEAD_BEEF, 1'b0, 0, t0);
        xfer(1'b0, 32'h0000_0008, 32'h1234_5678, 4'hA, 3'b010, 3, 32'h0000_0001, 1'b0, 0, t0);
        xfer(1'b1, 32'h0000_000C, 32'hCAFE_F00D, 4'h3, 3'b101, 0, 32'h0, 1'b1, 5, t0);

        // Reset in the middle of ACCESS: bus drops at once, no response follows.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0010; req_strb = 4'hF; pready = 1'b0;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_penable", {31'd0, penable}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_psel", {31'd0, psel}, 32'd0);
        chk("async_rst_penable", {31'd0, penable}, 32'd0);
        chk("async_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk); rst_n = 1'b1; pready = 1'b1; prdata = 32'h5555_AAAA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("post_abort_req_ready", {31'd0, req_ready}, 32'd1);
        end
        @(posedge clk); #1; pready = 1'b0;

`ifdef APB4_MASTER_TIMEOUT_EN
        // pready never arrives: 16 ACCESS cycles then an error response with no data.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0020; pready = 1'b0;
        @(posedge clk); #1; req_valid = 1'b0;
        nacc = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
            else if (penable) nacc++;
            prdata = $urandom; pslverr = 1'($urandom);
        end
        chk("to_done", {31'd0, got}, 32'd1);
        chk("to_access_cycles", nacc, 32'd16);
        chk("to_err", {31'd0, rsp_err}, 32'd1);
        chk("to_rdata", rsp_rdata, 32'd0);
        @(posedge clk); #1; rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
        // pready on the 16th ACCESS cycle wins over the limit.
        er = 1'($urandom);
        xfer(1'b0, 32'h0000_0024, 32'h0, 4'h0, 3'b001, 15, 32'h0BAD_F00D, er, 0, t0);
`endif

        // Back-to-back zero-wait transfers with the response consumed immediately.
        t1 = -1;
        for (int i = 0; i < 10; i++) begin
            wr = 1'($urandom); er = 1'($urandom);
            xfer(wr, $urandom, $urandom, 4'($urandom), 3'($urandom), 0, $urandom, er, 0, t0);
            if (t1 >= 0) chk("b2b_period", t0 - t1, 32'd4);
            t1 = t0;
        end

        // Random wait states and response stalls.
        for (int i = 0; i < 6; i++) begin
            wr = 1'($urandom); er = 1'($urandom);
            w = int'($urandom_range(0, 4)); h = int'($urandom_range(0, 2));
            xfer(wr, $urandom, $urandom, 4'($urandom), 3'($urandom), w, $urandom, er, h, t0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/apb4_master.md
Name: apb4_master

Overview:
- APB4 requester (initiator) bridge that turns a simple valid/ready request/response interface into APB4 master transactions.
- It sits between a local controller (debug module, DMA, boot loader) and the APB4 peripheral bus, and drives slaves such as the RCU, timers and UART.
- One transfer is outstanding at a time. The bridge follows the strict SETUP→ACCESS sequence and supports wait states, PSLVERR and PSTRB/PPROT.

Parameters:
ADDR_WIDTH, 32, width of paddr_o / req_addr_i
DATA_WIDTH, 32, width of data buses; must be a multiple of 8
TIMEOUT_CYCLES, 256, ACCESS-phase cycle limit (used only with the optional feature)

Ports:
clk_i  in  1  bus clock (PCLK)
rst_n_i  in  1  asynchronous active-low reset (PRESETn)
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&&ready
req_write_i  in  1  1=write, 0=read
req_addr_i  in  ADDR_WIDTH  byte address
req_wdata_i  in  DATA_WIDTH  write data
req_strb_i  in  DATA_WIDTH/8  write byte strobes
req_prot_i  in  3  PPROT value
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&&ready
rsp_rdata_o  out  DATA_WIDTH  read data (0 for writes)
rsp_err_o  out  1  PSLVERR or timeout
paddr_o  out  ADDR_WIDTH  APB address
pprot_o  out  3  APB protection
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwrite_o  out  1  APB direction
pwdata_o  out  DATA_WIDTH  APB write data
pstrb_o  out  DATA_WIDTH/8  APB strobes (0 on reads)
pready_i  in  1  APB ready
prdata_i  in  DATA_WIDTH  APB read data
pslverr_i  in  1  APB error

Behaviour:
- Reset (asynchronous, active-low, rst_n_i):
  - All registered outputs go to 0: psel_o, penable_o, pwrite_o, paddr_o, pwdata_o, pstrb_o, pprot_o, rsp_valid_o, rsp_rdata_o, rsp_err_o.
  - State goes to IDLE, so req_ready_o=1 once reset is released.
  - Reset asserted mid-transfer aborts the transfer immediately with no response; the bus returns idle.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready_o=1, driven combinationally from state==IDLE.
  - On valid&&ready, register addr, write, wdata, strb (forced to 0 on reads) and prot into the APB outputs, then go to SETUP.
- SETUP: psel_o=1, penable_o=0. Unconditionally go to ACCESS next cycle.
- ACCESS:
  - psel_o=1, penable_o=1.
  - All APB outputs stay stable until pready_i=1.
  - On pready_i: capture prdata_i (reads only; 0 for writes) and pslverr_i, drop psel_o/penable_o, set rsp_valid_o, go to RESP.
- RESP:
  - rsp_valid_o and response data are held stable until rsp_ready_i=1.
  - Then clear rsp_valid_o and go to IDLE.
  - No new request is accepted in RESP.
- Latency:
  - Request accepted at cycle T → SETUP at T+1 → ACCESS at T+2.
  - With zero wait states, rsp_valid_o is high at T+3.
  - Each wait state adds 1 cycle.
  - Back-to-back throughput is 4 cycles per transfer at minimum.
- Boundary conditions:
  - pready_i, prdata_i and pslverr_i are ignored outside ACCESS.
  - rsp_ready_i held high continuously: response lasts exactly 1 cycle.
  - req_valid_i asserted outside IDLE: ignored; request inputs may change freely until accepted.
  - paddr_o is passed unmodified; no alignment check.

Optional Feature:
- Macro: APB4_MASTER_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to ACCESS and increments every ACCESS cycle without pready_i.
  - When it reaches TIMEOUT_CYCLES with pready_i still low, the transfer ends: psel_o and penable_o drop, rsp_err_o=1, rsp_rdata_o=0, go to RESP.
  - If pready_i rises on the same cycle the limit is reached, pready_i wins and the normal response is returned.
- Not defined: no counter; ACCESS waits indefinitely for pready_i.

Decomposition:
- Shared package apb4_master_pkg holds:
  - the state enum typedef (IDLE/SETUP/ACCESS/RESP, 2 bits);
  - PPROT default constant 3'b000;
  - APB4_MASTER_STRB_WIDTH helper define.
- State and datapath registers use the existing dffr/dffer cells from register.sv.
- One sub-module is natural: apb4_master_timeout, the ACCESS-phase counter with a clear/enable/expired interface, instantiated only under APB4_MASTER_TIMEOUT_EN.

Test Plan:
- Write addr 0x0000_0004, data 0x0000_0003, strb 0xF, pready tied high:
  - psel=1 at T+1 and penable=1 at T+2 with paddr/pwdata stable;
  - rsp_valid at T+3 with err=0 and rdata=0.
- Read addr 0x0000_0008, slave asserts pready after 3 wait states with prdata=0x0000_0001:
  - ACCESS holds 4 cycles;
  - rsp_rdata=0x0000_0001 at T+6;
  - pstrb=0 throughout.
- Write with pslverr=1 on the ready cycle → rsp_err=1; keep rsp_ready=0 for 5 cycles → rsp_valid and rsp_err stable; req_ready=0 throughout.
- Assert rst_n_i low during ACCESS of a read → psel, penable and rsp_valid go to 0 asynchronously; after release req_ready=1 and no response is emitted.
- With APB4_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, pready held low:
  - the transfer ends after 16 ACCESS cycles with rsp_err=1 and rdata=0;
  - rerun with pready rising on cycle 16 → err=pslverr, normal data.
- 10 random back-to-back requests with rsp_ready always 1 and zero wait states → exactly 4 cycles per transfer; APB protocol checker reports no SETUP/ACCESS violations.
